// File: rtl/pool_feed.sv
// pool_feed: accepts 2x2 accumulator windows (one per mesh column per beat),
// computes the signed 2x2 max per column and buffers the raw windows and
// pooled values in a 2-entry FIFO for the buffer write controller.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   conf          start-of-line pulse, only honoured in IDLE
//   linelen       output columns in the line (sampled at conf)
//   pooled        1 = pooled line (one beat per column), 0 = unpooled (two columns per beat)
//   acc_data      windows; word k + 2*j + 4*i is column i, row j, position k
//   acc_valid     acc_data valid
//   acc_ready     beat accepted when acc_valid && acc_ready
//   out_data_4    FIFO head, raw window (same layout as acc_data)
//   out_data_1    FIFO head, per-column signed max of the 4 words
//   out_valid     FIFO non-empty
//   out_ready     downstream consume
//   busy          not IDLE
//   done          one-cycle pulse at end of line
module pool_feed #(
  parameter int X_MESH       = 16,
  parameter int COM_DATALEN  = 24,
  parameter int MAX_LINE_LEN = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            conf,
  input  logic [MAX_LINE_LEN-1:0]         linelen,
  input  logic                            pooled,
  input  logic [4*COM_DATALEN*X_MESH-1:0] acc_data,
  input  logic                            acc_valid,
  output logic                            acc_ready,
  output logic [4*COM_DATALEN*X_MESH-1:0] out_data_4,
  output logic [COM_DATALEN*X_MESH-1:0]   out_data_1,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done
);

  localparam int W1 = COM_DATALEN * X_MESH;
  localparam int W4 = 4 * W1;
  localparam int CW = MAX_LINE_LEN + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [CW-1:0]   len_ext;
  logic [CW-1:0]   beats;

  logic [1:0]      fifo_count_reg;
  logic            head_reg;
  logic            tail_reg;
  logic [W4-1:0]   mem4 [2];
  logic [W1-1:0]   mem1 [2];

  logic [W1-1:0]   max_vec;
  logic            push;
  logic            pop;

  // Per-column signed max of the four window words (two-level tree).
  generate
    for (genvar gi = 0; gi < X_MESH; gi++) begin : g_pool
      logic signed [COM_DATALEN-1:0] w0, w1, w2, w3, m01, m23;
      assign w0  = acc_data[(4*gi+0)*COM_DATALEN +: COM_DATALEN];
      assign w1  = acc_data[(4*gi+1)*COM_DATALEN +: COM_DATALEN];
      assign w2  = acc_data[(4*gi+2)*COM_DATALEN +: COM_DATALEN];
      assign w3  = acc_data[(4*gi+3)*COM_DATALEN +: COM_DATALEN];
      assign m01 = (w0 > w1) ? w0 : w1;
      assign m23 = (w2 > w3) ? w2 : w3;
      assign max_vec[gi*COM_DATALEN +: COM_DATALEN] = (m01 > m23) ? m01 : m23;
    end
  endgenerate

  // Unpooled beats carry two output columns; widen first so linelen = max
  // does not wrap when rounding up.
  assign len_ext = {1'b0, linelen};
  assign beats   = pooled ? len_ext : ((len_ext + CW'(1)) >> 1);

  // acc_ready depends only on registered state so out_ready never reaches it
  // combinationally.
  assign acc_ready  = (state_reg == S_RUN) && (fifo_count_reg < 2'd2);
  assign out_valid  = (fifo_count_reg != 2'd0);
  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_DONE);
  assign push       = acc_valid && acc_ready;
  assign pop        = out_valid && out_ready;
  assign out_data_4 = mem4[head_reg];
  assign out_data_1 = mem1[head_reg];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (conf) begin
          cnt_next   = beats;
          state_next = (beats != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (push) begin
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_count_reg == 2'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Storage is cleared on reset so the head outputs read zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count_reg <= 2'd0;
      head_reg       <= 1'b0;
      tail_reg       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem4[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (push) begin
        mem4[tail_reg] <= acc_data;
        mem1[tail_reg] <= max_vec;
        tail_reg       <= ~tail_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 2'd1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 2'd1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_feed.sv
// tb_pool_feed: directed scenarios plus randomized traffic for pool_feed,
// checked every cycle against a queue-based behavioural model.
module tb_pool_feed;

  localparam int XM = 16;
  localparam int DL = 24;
  localparam int LL = 10;
  localparam int W1 = DL * XM;
  localparam int W4 = 4 * W1;

  logic          clk;
  logic          rst;
  logic          conf;
  logic [LL-1:0] linelen;
  logic          pooled;
  logic [W4-1:0] acc_data;
  logic          acc_valid;
  logic          acc_ready;
  logic [W4-1:0] out_data_4;
  logic [W1-1:0] out_data_1;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  pool_feed #(.X_MESH(XM), .COM_DATALEN(DL), .MAX_LINE_LEN(LL)) dut (
    .clk        (clk),
    .rst        (rst),
    .conf       (conf),
    .linelen    (linelen),
    .pooled     (pooled),
    .acc_data   (acc_data),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .out_data_4 (out_data_4),
    .out_data_1 (out_data_1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [W4-1:0] d4;
    logic [W1-1:0] d1;
  } ent_t;

  ent_t m_q[$];
  int   m_phase = 0;   // 0 idle, 1 taking beats, 2 draining, 3 done pulse
  int   m_left  = 0;

  function automatic logic [W1-1:0] ref_pool(input logic [W4-1:0] d);
    logic [W1-1:0] r;
    int best, v;
    r = '0;
    for (int c = 0; c < XM; c++) begin
      best = int'($signed(d[(4*c)*DL +: DL]));
      for (int k = 1; k < 4; k++) begin
        v = int'($signed(d[(4*c+k)*DL +: DL]));
        if (v > best) best = v;
      end
      r[c*DL +: DL] = DL'(best);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_left  = 0;
  endtask

  task automatic model_step();
    int   qs;
    bit   acc, pp;
    ent_t e;
    int   nb;
    qs  = m_q.size();
    acc = (m_phase == 1) && (qs < 2) && acc_valid;
    pp  = (qs > 0) && out_ready;
    if (pp) void'(m_q.pop_front());
    if (acc) begin
      e.d4 = acc_data;
      e.d1 = ref_pool(acc_data);
      m_q.push_back(e);
    end
    case (m_phase)
      0: if (conf) begin
           nb      = pooled ? int'(linelen) : (int'(linelen) + 1) / 2;
           m_left  = nb;
           m_phase = (nb > 0) ? 1 : 3;
         end
      1: if (acc) begin
           m_left--;
           if (m_left == 0) m_phase = 2;
         end
      2: if (qs == 0) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("acc_ready", 96'(acc_ready), 96'((m_phase == 1) && (m_q.size() < 2)));
    chk("out_valid", 96'(out_valid), 96'(m_q.size() > 0));
    chk("busy",      96'(busy),      96'(m_phase != 0));
    chk("done",      96'(done),      96'(m_phase == 3));
    if (m_q.size() > 0) begin
      for (int c = 0; c < XM; c++) begin
        chk("head_max", 96'(out_data_1[c*DL +: DL]), 96'(m_q[0].d1[c*DL +: DL]));
        chk("head_raw", out_data_4[c*4*DL +: 4*DL], m_q[0].d4[c*4*DL +: 4*DL]);
      end
    end
  end

  // Event monitors used by directed checks.
  int acc_cnt  = 0;
  int done_cnt = 0;
  logic [DL-1:0] pop_log[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (acc_valid && acc_ready) acc_cnt++;
      if (done) done_cnt++;
      if (out_valid && out_ready) pop_log.push_back(out_data_4[DL-1:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [W4-1:0] rnd4();
    logic [W4-1:0] r;
    for (int i = 0; i < W4 / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_word(input int c, input int k, input int v);
    acc_data[(4*c+k)*DL +: DL] = DL'(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 96'(0), 96'(1));
  endtask

  task automatic idle(input int n);
    acc_valid = 1'b0;
    conf      = 1'b0;
    repeat (n) tick();
  endtask

  int a0, d0;

  initial begin
    rst = 1'b1; conf = 1'b0; linelen = '0; pooled = 1'b0;
    acc_data = '0; acc_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_acc_ready", 96'(acc_ready), 96'(0));
    chk("rst_out_valid", 96'(out_valid), 96'(0));
    chk("rst_busy",      96'(busy),      96'(0));
    chk("rst_done",      96'(done),      96'(0));
    chk("rst_out_data1", 96'(out_data_1[95:0]), 96'(0));
    tick();
    rst = 1'b0;
    idle(2);

    // Pooled line of 3, column 0 window {5,-2,9,7} on beat 0.
    a0 = acc_cnt; d0 = done_cnt;
    acc_data = rnd4();
    set_word(0, 0, 5); set_word(0, 1, -2); set_word(0, 2, 9); set_word(0, 3, 7);
    pooled = 1'b1; linelen = 10'd3; conf = 1'b1; acc_valid = 1'b1; out_ready = 1'b1;
    tick();
    conf = 1'b0;
    tick();
    acc_data = rnd4();
    @(negedge clk);
    chk("pool_max9", 96'(out_data_1[DL-1:0]), 96'(9));
    chk("pool_raw9", 96'(out_data_4[2*DL +: DL]), 96'(9));
    wait_done(40);
    chk("pool_busy_at_done", 96'(busy), 96'(1));
    @(negedge clk);
    chk("pool_done_fall", 96'(done), 96'(0));
    chk("pool_busy_fall", 96'(busy), 96'(0));
    chk("pool_beats", 96'(acc_cnt - a0), 96'(3));
    chk("pool_done_once", 96'(done_cnt - d0), 96'(1));
    idle(2);

    // Unpooled line of 5 -> 3 beats, then acc_ready stays low.
    a0 = acc_cnt;
    pooled = 1'b0; linelen = 10'd5; conf = 1'b1; acc_valid = 1'b1; acc_data = rnd4();
    tick();
    conf = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    chk("unpool5_ready_low", 96'(acc_ready), 96'(0));
    chk("unpool5_beats", 96'(acc_cnt - a0), 96'(3));
    // Unpooled line of 0: straight to done, nothing accepted.
    a0 = acc_cnt; d0 = done_cnt;
    tick();
    linelen = 10'd0; conf = 1'b1;
    tick();
    conf = 1'b0;
    @(negedge clk);
    chk("unpool0_done", 96'(done), 96'(1));
    tick();
    tick();
    chk("unpool0_beats", 96'(acc_cnt - a0), 96'(0));
    chk("unpool0_done_once", 96'(done_cnt - d0), 96'(1));
    idle(2);

    // Backpressure: three tagged beats A,B,C with out_ready low.
    a0 = acc_cnt;
    pop_log.delete();
    out_ready = 1'b0; pooled = 1'b1; linelen = 10'd3;
    acc_data = rnd4(); acc_data[DL-1:0] = DL'(111);
    conf = 1'b1; acc_valid = 1'b1;
    tick();
    conf = 1'b0;
    tick();                                   // A accepted
    acc_data = rnd4(); acc_data[DL-1:0] = DL'(222);
    tick();                                   // B accepted
    acc_data = rnd4(); acc_data[DL-1:0] = DL'(333);
    @(negedge clk);
    chk("bp_ready_low", 96'(acc_ready), 96'(0));
    chk("bp_head_A", 96'(out_data_4[DL-1:0]), 96'(111));
    tick();
    @(negedge clk);
    chk("bp_head_A_hold", 96'(out_data_4[DL-1:0]), 96'(111));
    chk("bp_two_accepts", 96'(acc_cnt - a0), 96'(2));
    tick();
    out_ready = 1'b1;
    wait_done(40);
    chk("bp_pop_count", 96'(pop_log.size()), 96'(3));
    if (pop_log.size() == 3) begin
      chk("bp_pop_A", 96'(pop_log[0]), 96'(111));
      chk("bp_pop_B", 96'(pop_log[1]), 96'(222));
      chk("bp_pop_C", 96'(pop_log[2]), 96'(333));
    end
    idle(2);

    // Signed max edge cases.
    acc_data = rnd4();
    set_word(1, 0, -8388608); set_word(1, 1, -1); set_word(1, 2, -5); set_word(1, 3, -8388607);
    for (int k = 0; k < 4; k++) set_word(2, k, 100);
    pooled = 1'b1; linelen = 10'd1; conf = 1'b1; acc_valid = 1'b1; out_ready = 1'b1;
    tick();
    conf = 1'b0;
    tick();
    @(negedge clk);
    chk("max_neg", 96'(out_data_1[DL +: DL]), 96'(24'hFFFFFF));
    chk("max_equal", 96'(out_data_1[2*DL +: DL]), 96'(100));
    wait_done(20);
    idle(2);

    // Reset mid-line with one FIFO entry held.
    pooled = 1'b1; linelen = 10'd4; out_ready = 1'b0; acc_valid = 1'b1; acc_data = rnd4();
    conf = 1'b1;
    tick();
    conf = 1'b0;
    tick();
    acc_valid = 1'b0;
    @(negedge clk);
    chk("mid_valid_before", 96'(out_valid), 96'(1));
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_valid", 96'(out_valid), 96'(0));
    chk("mid_rst_ready", 96'(acc_ready), 96'(0));
    chk("mid_rst_busy",  96'(busy),      96'(0));
    chk("mid_rst_done",  96'(done),      96'(0));
    tick();
    rst = 1'b0;
    tick();
    a0 = acc_cnt; d0 = done_cnt;
    pooled = 1'b1; linelen = 10'd1; out_ready = 1'b1; acc_valid = 1'b1; conf = 1'b1;
    tick();
    conf = 1'b0;
    wait_done(20);
    tick();
    chk("mid_new_beats", 96'(acc_cnt - a0), 96'(1));
    chk("mid_new_done", 96'(done_cnt - d0), 96'(1));
    idle(2);

    // conf during RUN is ignored.
    a0 = acc_cnt; d0 = done_cnt;
    pooled = 1'b1; linelen = 10'd2; out_ready = 1'b1; acc_valid = 1'b0; conf = 1'b1;
    tick();
    conf = 1'b0;
    tick();
    linelen = 10'd7; conf = 1'b1;
    tick();
    conf = 1'b0; acc_valid = 1'b1; acc_data = rnd4();
    wait_done(30);
    tick();
    chk("run_conf_beats", 96'(acc_cnt - a0), 96'(2));
    chk("run_conf_done", 96'(done_cnt - d0), 96'(1));
    idle(2);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      acc_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      conf      = ($urandom_range(5) == 0);
      pooled    = $urandom_range(1) != 0;
      linelen   = LL'($urandom_range(7));
      acc_data  = rnd4();
      if ($urandom_range(499) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
